muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the execute stage of the pipelined MIPS core; successor to the fixed 32-bit multiplier start/done pair.
- Supports signed/unsigned multiply and divide at any WIDTH, with architectural HI/LO registers, an MTHI/MTLO write port, a busy/done handshake to the hazard unit, and flush abort.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_core.sv | 62 ++++++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned MD_OP_W = 2;

   typedef logic [MD_OP_W-1:0] md_op_t;

   localparam md_op_t MD_MULT  = 2'b00;
   localparam md_op_t MD_MULTU = 2'b01;
   localparam md_op_t MD_DIV   = 2'b10;
   localparam md_op_t MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2,
      FIN  = 2'd3
   } md_state_t;

   // Divide ops have the high op bit set.
   function automatic logic op_is_div(input md_op_t op_in);
      return op_in[1];
   endfunction

   // Signed ops have the low op bit clear.
   function automatic logic op_is_signed(input md_op_t op_in);
      return ~op_in[0];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: shift-add multiply or restoring divide over a 2*WIDTH accumulator.
// Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] acc_hi,
   output logic [WIDTH-1:0] acc_lo
);

   localparam int unsigned W2 = 2 * WIDTH;

   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // Next accumulator: load on init, one multiply or divide step per cycle on step.
   always_comb begin
      acc_d   = acc_q;
      opb_d   = opb_q;
      add_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      rem_sh  = acc_q[W2-1:WIDTH-1];
      diff    = rem_sh - {1'b0, opb_q};
      if (init) begin
         acc_d = {WIDTH'(0), op_a};
         opb_d = op_b;
      end else if (step) begin
         if (!is_div) begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
         end else if (!diff[WIDTH]) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Accumulator and operand registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         opb_q <= '0;
      end else begin
         acc_q <= acc_d;
         opb_q <= opb_d;
      end
   end

   assign acc_hi = acc_q[W2-1:WIDTH];
   assign acc_lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: control FSM, sign handling, HI/LO registers and busy/done handshake.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned W2    = 2 * WIDTH;

   md_state_t        state_q, state_d;
   md_op_t           op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic             sgn_a, sgn_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [W2-1:0]    prod;
   logic [WIDTH-1:0] quo, rem;
   logic             core_init, core_step;

   // Operand magnitudes and signs for the PREP cycle.
   always_comb begin
      sgn_a = op_is_signed(op_q) & a_q[WIDTH-1];
      sgn_b = op_is_signed(op_q) & b_q[WIDTH-1];
      mag_a = sgn_a ? (~a_q + WIDTH'(1)) : a_q;
      mag_b = sgn_b ? (~b_q + WIDTH'(1)) : b_q;
   end

   // Sign-corrected results from the finished accumulator.
   always_comb begin
      prod = {acc_hi, acc_lo};
      if (negq_q) begin
         prod = ~prod + W2'(1);
      end
      quo = acc_lo;
      if (dz_q) begin
         quo = '1;
      end else if (negq_q) begin
         quo = ~acc_lo + WIDTH'(1);
      end
      rem = negr_q ? (~acc_hi + WIDTH'(1)) : acc_hi;
   end

   assign core_init = (state_q == PREP);
   assign core_step = (state_q == RUN);

   muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .init   (core_init),
      .step   (core_step),
      .is_div (op_is_div(op_q)),
      .op_a   (mag_a),
      .op_b   (mag_b),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo)
   );

   // Next-state and register updates; flush aborts any in-flight operation.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start && !flush) begin
               state_d = PREP;
               op_d    = md_op_t'(op);
               a_d     = a;
               b_d     = b;
               busy_d  = 1'b1;
            end
         end
         PREP: begin
            state_d = RUN;
            cnt_d   = '0;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
            dz_d    = op_is_div(op_q) & (b_q == '0);
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dbz_d   = dz_q;
            if (op_is_div(op_q)) begin
               hi_d = rem;
               lo_d = quo;
            end else begin
               hi_d = prod[W2-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush && (state_q != IDLE)) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   // State and register file with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= MD_MULT;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, flush, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   int lat;
   int busy_bad;
   int done_seen;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request; it is sampled at the next rising edge.
   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count edges after the accepting edge until done; busy must hold high meanwhile.
   task automatic wait_done(output int l, output int bad);
      l = 0;
      bad = 0;
      while (!done && l < 100) begin
         if (!busy) bad++;
         @(posedge clk); #1;
         l++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; a = '0; b = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dbz", div_by_zero, 0);

      // MULT -3 * 7
      @(negedge clk);
      start_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat, busy_bad);
      chk("mult_latency", lat, 34);
      chk("mult_busy_during", busy_bad, 0);
      chk("mult_busy_at_done", busy, 0);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("mult_dbz", div_by_zero, 0);
      @(posedge clk); #1;
      chk("mult_done_drop", done, 0);

      // MULTU all ones squared
      @(negedge clk);
      start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, busy_bad);
      chk("multu_hi", hi, 64'hFFFF_FFFE);
      chk("multu_lo", lo, 64'h0000_0001);

      // DIV -7 / 2
      @(negedge clk);
      start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, busy_bad);
      chk("div_latency", lat, 34);
      chk("div_lo", lo, 64'hFFFF_FFFD);
      chk("div_hi", hi, 64'hFFFF_FFFF);

      // DIVU 100 / 7
      @(negedge clk);
      start_op(MD_DIVU, 32'd100, 32'd7);
      wait_done(lat, busy_bad);
      chk("divu_lo", lo, 64'd14);
      chk("divu_hi", hi, 64'd2);

      // DIV overflow: most-negative / -1
      @(negedge clk);
      start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, busy_bad);
      chk("divovf_lo", lo, 64'h8000_0000);
      chk("divovf_hi", hi, 64'd0);

      // DIVU by zero
      @(negedge clk);
      start_op(MD_DIVU, 32'd5, 32'd0);
      wait_done(lat, busy_bad);
      chk("dbz_latency", lat, 34);
      chk("dbz_lo", lo, 64'hFFFF_FFFF);
      chk("dbz_hi", hi, 64'd5);
      chk("dbz_pulse", div_by_zero, 1);
      @(posedge clk); #1;
      chk("dbz_pulse_drop", div_by_zero, 0);

      // Flush mid-operation: no done, hi/lo kept
      @(negedge clk);
      start_op(MD_MULT, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      @(negedge clk) flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_busy", busy, 0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      chk("flush_no_done", done_seen, 0);
      chk("flush_hi", hi, 64'd5);
      chk("flush_lo", lo, 64'hFFFF_FFFF);

      // Reset mid-operation
      @(negedge clk);
      start_op(MD_MULT, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("rst_mid_hi", hi, 0);
      chk("rst_mid_lo", lo, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_dbz", div_by_zero, 0);

      // Flush and start together: nothing starts
      @(negedge clk);
      flush = 1'b1;
      start_op(MD_MULTU, 32'd2, 32'd3);
      flush = 1'b0;
      chk("flush_start_busy", busy, 0);
      @(posedge clk); #1;
      chk("flush_start_busy2", busy, 0);

      // MTLO while idle
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h1234;
      @(posedge clk); #1 lo_we = 1'b0;
      chk("mtlo_idle", lo, 64'h1234);

      // Write and start while busy are both ignored
      @(negedge clk);
      start_op(MD_MULTU, 32'd2, 32'd3);
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'hBEEF;
      op = MD_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
      @(posedge clk); #1 lo_we = 1'b0; start = 1'b0;
      chk("mtlo_busy_ignored", lo, 64'h1234);
      wait_done(lat, busy_bad);
      chk("busy_start_lo", lo, 64'd6);
      chk("busy_start_hi", hi, 64'd0);
      chk("busy_start_total_lat", lat, 33);

      // Start in the done cycle is accepted
      start_op(MD_DIVU, 32'd100, 32'd7);
      chk("done_cycle_start_busy", busy, 1);
      wait_done(lat, busy_bad);
      chk("done_cycle_latency", lat, 34);
      chk("done_cycle_lo", lo, 64'd14);
      chk("done_cycle_hi", hi, 64'd2);
      @(posedge clk); #1;
      chk("idle_after_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
